// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one 8N1 UART transmitter between NUM_REQ byte streams.
// Define UART_ARB_ID_HDR_EN to prefix every packet with a header byte 8'hA0 | requester index.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int GAP_TIMEOUT = 1_000_000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 tx_start_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_busy_i,
  output logic                 active_o,
  output logic                 timeout_o
);

  localparam int GAP_W = (GAP_TIMEOUT > 2) ? $clog2(GAP_TIMEOUT) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3
`ifdef UART_ARB_ID_HDR_EN
    ,ST_HDR      = 3'd4
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]    gidx_q, gidx_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               active_q, active_d;
  logic               timeout_q, timeout_d;
  logic               last_q, last_d;
  logic [GAP_W-1:0]   gap_q, gap_d;

  logic [ID_W-1:0]    win_idx;
  logic [ID_W-1:0]    scan_idx;
  logic               win_found;
  logic               sel_valid;
  logic               sel_last;
  logic [7:0]         sel_data;
  logic [ID_W-1:0]    next_ptr;

  // Round-robin search starting at the pointer; first valid requester wins.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_found && req_valid_i[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) begin
        sel_valid = req_valid_i[k];
        sel_last  = req_last_i[k];
        sel_data  = req_data_i[8*k +: 8];
      end
    end
  end

  assign next_ptr = (gidx_q == ID_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    ptr_d      = ptr_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    active_d   = active_q;
    timeout_d  = 1'b0;
    last_d     = last_q;
    gap_d      = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          grant_d  = NUM_REQ'(1) << win_idx;
          gidx_d   = win_idx;
          active_d = 1'b1;
          gap_d    = '0;
`ifdef UART_ARB_ID_HDR_EN
          state_d  = ST_HDR;
`else
          state_d  = ST_SEND;
`endif
        end
      end
`ifdef UART_ARB_ID_HDR_EN
      ST_HDR: begin
        tx_data_d  = 8'hA0 | 8'(gidx_q);
        tx_start_d = 1'b1;
        last_d     = 1'b0;
        state_d    = ST_WAIT_BUSY;
      end
`endif
      ST_SEND: begin
        if (sel_valid) begin
          tx_data_d  = sel_data;
          tx_start_d = 1'b1;
          last_d     = sel_last;
          gap_d      = '0;
          state_d    = ST_WAIT_BUSY;
        end else if (gap_q == GAP_LAST) begin
          // Stalled mid-packet too long: drop the rest of this packet.
          timeout_d = 1'b1;
          grant_d   = '0;
          active_d  = 1'b0;
          ptr_d     = next_ptr;
          gap_d     = '0;
          state_d   = ST_IDLE;
        end else if (gap_q != '1) begin
          gap_d = gap_q + 1'b1;
        end
      end
      ST_WAIT_BUSY: begin
        if (tx_busy_i) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!tx_busy_i) begin
          if (last_q) begin
            grant_d  = '0;
            active_d = 1'b0;
            ptr_d    = next_ptr;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_SEND;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      ptr_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      active_q   <= 1'b0;
      timeout_q  <= 1'b0;
      last_q     <= 1'b0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      ptr_q      <= ptr_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      active_q   <= active_d;
      timeout_q  <= timeout_d;
      last_q     <= last_d;
      gap_q      <= gap_d;
    end
  end

  assign req_ready_o = (state_q == ST_SEND) ? grant_q : '0;
  assign grant_o     = grant_q;
  assign tx_start_o  = tx_start_q;
  assign tx_data_o   = tx_data_q;
  assign active_o    = active_q;
  assign timeout_o   = timeout_q;

endmodule
